// File: rtl/rng_arbiter.sv
// rng_arbiter: 32-bit LFSR random word source shared by NUM_REQ requesters through
// a registered round-robin grant, with post-seed warmup, reseed limit and health tests.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// UNSEEDED | no usable seed (after reset or reseed limit); LFSR held, no grants
// WARMUP   | LFSR stepping, discarding WARMUP_CYCLES states after a seed load
// SERVE    | LFSR stepping, one grant per edge while any request is pending
// FAULT    | zero seed or health test failure; LFSR held until a nonzero seed
module rng_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WARMUP_CYCLES = 32,
    parameter int RESEED_LIMIT  = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        seed,
    input  logic               seed_load,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_out,
    output logic               rnd_valid,
    output logic               need_seed,
    output logic               fault
);

    localparam int               IDX_W      = $clog2(NUM_REQ);
    localparam int               IDX_W1     = IDX_W + 1;
    localparam logic [7:0]       WARM_LAST  = 8'(WARMUP_CYCLES - 1);
    localparam logic [15:0]      DELIV_LAST = 16'(RESEED_LIMIT - 1);
    localparam logic [IDX_W-1:0] RR_RESET   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        WARMUP   = 2'd1,
        SERVE    = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [31:0]        lfsr_q,      lfsr_d;
    logic [7:0]         warm_cnt_q,  warm_cnt_d;
    logic [15:0]        deliv_cnt_q, deliv_cnt_d;
    logic [31:0]        prev_word_q, prev_word_d;
    logic [IDX_W-1:0]   rr_last_q,   rr_last_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [31:0]        rnd_q,       rnd_d;
    logic               fault_q,     fault_d;
    logic               need_seed_q, need_seed_d;

    logic [31:0]        lfsr_step;
    logic [IDX_W-1:0]   pick;
    logic               found;

    assign lfsr_step = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[29] ^ lfsr_q[25] ^ lfsr_q[24]};

    // Round-robin search begins one past the last granted index, wrapping at NUM_REQ.
    always_comb begin : rr_search
        logic [IDX_W1-1:0] idx;
        pick  = rr_last_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = {1'b0, rr_last_q} + IDX_W1'(i);
            if (idx >= IDX_W1'(NUM_REQ)) begin
                idx = idx - IDX_W1'(NUM_REQ);
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        warm_cnt_d  = warm_cnt_q;
        deliv_cnt_d = deliv_cnt_q;
        prev_word_d = prev_word_q;
        rr_last_d   = rr_last_q;
        fault_d     = fault_q;
        need_seed_d = need_seed_q;
        gnt_d       = '0;
        rnd_d       = '0;

        if (seed_load) begin
            // A seed strobe overrides everything, including a pending grant.
            if (seed != 32'd0) begin
                lfsr_d      = seed;
                warm_cnt_d  = '0;
                deliv_cnt_d = '0;
                fault_d     = 1'b0;
                need_seed_d = 1'b0;
                state_d     = WARMUP;
            end else begin
                state_d     = FAULT;
                fault_d     = 1'b1;
                need_seed_d = 1'b1;
            end
        end else begin
            case (state_q)
                WARMUP: begin
                    if (lfsr_q == 32'd0) begin
                        state_d     = FAULT;
                        fault_d     = 1'b1;
                        need_seed_d = 1'b1;
                    end else begin
                        lfsr_d     = lfsr_step;
                        warm_cnt_d = warm_cnt_q + 8'd1;
                        if (warm_cnt_q == WARM_LAST) begin
                            state_d = SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (lfsr_q == 32'd0) begin
                        state_d     = FAULT;
                        fault_d     = 1'b1;
                        need_seed_d = 1'b1;
                    end else begin
                        lfsr_d = lfsr_step;
                        if (found) begin
                            // The delivered word is the pre-step state; a repeat is never delivered.
                            if (lfsr_q == prev_word_q) begin
                                state_d     = FAULT;
                                fault_d     = 1'b1;
                                need_seed_d = 1'b1;
                            end else begin
                                gnt_d[pick] = 1'b1;
                                rnd_d       = lfsr_q;
                                prev_word_d = lfsr_q;
                                rr_last_d   = pick;
                                deliv_cnt_d = deliv_cnt_q + 16'd1;
                                if (deliv_cnt_q == DELIV_LAST) begin
                                    state_d     = UNSEEDED;
                                    need_seed_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNSEEDED;
            lfsr_q      <= '0;
            warm_cnt_q  <= '0;
            deliv_cnt_q <= '0;
            prev_word_q <= '0;
            rr_last_q   <= RR_RESET;
            gnt_q       <= '0;
            rnd_q       <= '0;
            fault_q     <= 1'b0;
            need_seed_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            warm_cnt_q  <= warm_cnt_d;
            deliv_cnt_q <= deliv_cnt_d;
            prev_word_q <= prev_word_d;
            rr_last_q   <= rr_last_d;
            gnt_q       <= gnt_d;
            rnd_q       <= rnd_d;
            fault_q     <= fault_d;
            need_seed_q <= need_seed_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_out   = rnd_q;
    assign rnd_valid = |gnt_q;
    assign need_seed = need_seed_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed and randomized checks of rng_arbiter against a
// transaction-level model (word = seed advanced by steps since the seed load).
module tb_rng_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int WARMUP_CYCLES = 4;
    localparam int RESEED_LIMIT  = 8;

    logic               clk;
    logic               rst;
    logic [31:0]        seed;
    logic               seed_load;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [31:0]        rnd_out;
    logic               rnd_valid;
    logic               need_seed;
    logic               fault;

    rng_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .WARMUP_CYCLES(WARMUP_CYCLES),
        .RESEED_LIMIT (RESEED_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seed     (seed),
        .seed_load(seed_load),
        .req      (req),
        .gnt      (gnt),
        .rnd_out  (rnd_out),
        .rnd_valid(rnd_valid),
        .need_seed(need_seed),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    logic               m_seeded;
    logic               m_fault;
    logic [31:0]        m_seed;
    int                 m_steps;
    int                 m_delivered;
    int                 m_last;
    logic [31:0]        m_prev;
    logic [NUM_REQ-1:0] exp_gnt;
    logic [31:0]        exp_rnd;
    logic               exp_need;

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
        logic [31:0] v;
        v = s;
        for (int k = 0; k < n; k++) v = {v[30:0], v[31] ^ v[29] ^ v[25] ^ v[24]};
        return v;
    endfunction

    function automatic void model_reset();
        m_seeded    = 1'b0;
        m_fault     = 1'b0;
        m_seed      = '0;
        m_steps     = 0;
        m_delivered = 0;
        m_last      = NUM_REQ - 1;
        m_prev      = '0;
        exp_gnt     = '0;
        exp_rnd     = '0;
        exp_need    = 1'b1;
    endfunction

    function automatic void model_edge(input logic [NUM_REQ-1:0] r, input logic ld,
                                       input logic [31:0] s);
        logic [31:0] word;
        int          sel;
        exp_gnt = '0;
        exp_rnd = '0;
        if (ld) begin
            if (s != 32'd0) begin
                m_seed      = s;
                m_steps     = 0;
                m_delivered = 0;
                m_fault     = 1'b0;
                m_seeded    = 1'b1;
            end else begin
                m_fault = 1'b1;
            end
        end else if (m_seeded && !m_fault && m_delivered < RESEED_LIMIT) begin
            if (m_steps >= WARMUP_CYCLES && r != '0) begin
                word = lfsr_adv(m_seed, m_steps);
                if (word == m_prev) begin
                    m_fault = 1'b1;
                end else begin
                    sel = -1;
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        if (sel < 0 && r[(m_last + k) % NUM_REQ]) sel = (m_last + k) % NUM_REQ;
                    end
                    exp_gnt[sel] = 1'b1;
                    exp_rnd      = word;
                    m_prev       = word;
                    m_last       = sel;
                    m_delivered++;
                end
            end
            m_steps++;
        end
        exp_need = !m_seeded || m_fault || (m_delivered >= RESEED_LIMIT);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input logic [NUM_REQ-1:0] r, input logic ld, input logic [31:0] s);
        req       = r;
        seed_load = ld;
        seed      = s;
        @(posedge clk);
        cyc++;
        model_edge(r, ld, s);
        #1;
        check("gnt",       32'(gnt),       32'(exp_gnt));
        check("rnd_valid", 32'(rnd_valid), 32'(exp_gnt != '0));
        check("rnd_out",   rnd_out,        exp_rnd);
        check("fault",     32'(fault),     32'(m_fault));
        check("need_seed", 32'(need_seed), 32'(exp_need));
    endtask

    initial begin
        int                 n;
        logic               ld;
        logic [31:0]        s;
        logic [NUM_REQ-1:0] req_v;

        req       = '0;
        seed_load = 1'b0;
        seed      = '0;
        rst       = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_gnt",       32'(gnt),       32'd0);
        check("rst_rnd_valid", 32'(rnd_valid), 32'd0);
        check("rst_rnd_out",   rnd_out,        32'd0);
        check("rst_fault",     32'(fault),     32'd0);
        check("rst_need_seed", 32'(need_seed), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // No seed: requests wait, nothing granted
        for (int i = 0; i < 50; i++) step(4'b1111, 1'b0, 32'd0);

        // Seed 1, warmup 4 -> first served word is 0x10, granted to requester 2
        step(4'b0100, 1'b1, 32'h0000_0001);
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 32'd0);
        step(4'b0100, 1'b0, 32'd0);
        check("first_gnt", 32'(gnt), 32'h4);
        check("first_rnd", rnd_out, 32'h10);

        // Continuous requests: exactly RESEED_LIMIT grants per seed
        n = 0;
        for (int i = 0; i < 24; i++) begin
            step(4'b1111, (i == 0), 32'h1234_5678);
            if (gnt != '0) n++;
        end
        check("limit_grants", 32'(n), 32'(RESEED_LIMIT));
        check("limit_need_seed", 32'(need_seed), 32'd1);

        // Zero seed faults; a good seed clears the fault
        step(4'b0000, 1'b1, 32'd0);
        check("zero_seed_fault", 32'(fault), 32'd1);
        step(4'b0000, 1'b1, 32'hACE1_ACE1);
        check("reseed_fault_clr", 32'(fault), 32'd0);
        check("reseed_need_clr", 32'(need_seed), 32'd0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 32'd0);

        // Seed load and request on the same SERVE edge: load wins, request served after warmup
        step(4'b0010, 1'b1, 32'h0BAD_F00D);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (gnt == 4'b0010) break;
            step(4'b0010, 1'b0, 32'd0);
            n++;
        end
        check("collide_latency", 32'(n), 32'(WARMUP_CYCLES + 1));

        // Same seed again: first candidate repeats the last delivered word
        step(4'b0010, 1'b1, 32'h0BAD_F00D);
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b0, 32'd0);
        check("repeat_fault", 32'(fault), 32'd1);
        check("repeat_no_gnt", 32'(gnt), 32'd0);

        // Asynchronous reset in the middle of a grant cycle
        step(4'b1111, 1'b1, 32'hACE1_ACE1);
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 32'd0);
        check("pre_rst_valid", 32'(rnd_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_gnt",       32'(gnt),       32'd0);
        check("midrst_rnd_valid", 32'(rnd_valid), 32'd0);
        check("midrst_rnd_out",   rnd_out,        32'd0);
        check("midrst_need_seed", 32'(need_seed), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized requesters that hold until granted, with random reseeds
        req_v = '0;
        for (int c = 0; c < 800; c++) begin
            req_v = (req_v & ~exp_gnt) |
                    NUM_REQ'($urandom_range(0, 15) & $urandom_range(0, 15));
            ld = (exp_need && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 79) == 0);
            s  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            step(req_v, ld, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (range 2..8).
REQ-002 Parameter WARMUP_CYCLES, default 32, SHALL set the LFSR steps discarded after each seed load (range 1..255).
REQ-003 Parameter RESEED_LIMIT, default 4096, SHALL set the words delivered per seed before reseed is forced (range 2..65535).
REQ-004 clk  input  1  SHALL be the clock; all state changes on rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 seed  input  32  SHALL be the seed value, sampled when seed_load=1.
REQ-007 seed_load  input  1  SHALL be a single-cycle seed load strobe.
REQ-008 req  input  NUM_REQ  SHALL carry per-requester random-word requests, held until granted.
REQ-009 gnt  output  NUM_REQ  SHALL be a one-hot grant, high one cycle per delivered word.
REQ-010 rnd_out  output  32  SHALL be the delivered random word.
REQ-011 rnd_valid  output  1  SHALL qualify rnd_out; high exactly when gnt is nonzero.
REQ-012 need_seed  output  1  SHALL be high when the block requires a seed load.
REQ-013 fault  output  1  SHALL be high when a health-test failure is latched.

Function
REQ-014 Internal 32-bit LFSR SHALL step as next = {s[30:0], s[31]^s[29]^s[25]^s[24]}.
REQ-015 FSM states SHALL be UNSEEDED, WARMUP, SERVE and FAULT.
REQ-016 In UNSEEDED and FAULT the LFSR SHALL hold and no grant SHALL issue.
REQ-017 In WARMUP and SERVE the LFSR SHALL step every cycle.
REQ-018 seed_load=1 with seed!=0, in any state, SHALL do all of the following: lfsr<=seed; warmup and delivered counters cleared; fault<=0; need_seed<=0; state<=WARMUP.
REQ-019 seed_load=1 with seed==0 SHALL do all of the following: state<=FAULT; fault<=1; need_seed<=1; LFSR unchanged.
REQ-020 WARMUP SHALL count LFSR steps and, after exactly WARMUP_CYCLES steps, enter SERVE.
REQ-021 In SERVE, if any req bit is 1 at an edge, that edge SHALL register one grant, visible on gnt, rnd_valid and rnd_out in the following cycle (latency 1).
REQ-022 rnd_out for a grant SHALL equal the LFSR state at the granting edge (the pre-step value).
REQ-023 Arbitration SHALL be round-robin: search starts at the index after the last granted one; after reset, index 0 is highest priority.
REQ-024 At most one grant SHALL issue per cycle; back-to-back grants, including to the same requester, are permitted.
REQ-025 Because the grant is registered, a requester SHALL drop req in the gnt cycle; req still high in the gnt cycle counts as a new request.
REQ-026 When rnd_valid=0, rnd_out SHALL be 0x00000000 (no leakage of LFSR state).
REQ-027 Health test (repetition): a candidate word equal to the previously delivered word SHALL NOT be granted, and SHALL cause state<=FAULT, fault<=1, need_seed<=1.
REQ-028 Health test (zero state): LFSR state 0 in WARMUP or SERVE SHALL cause state<=FAULT, fault<=1, need_seed<=1.
REQ-029 When the delivered counter reaches RESEED_LIMIT, the block SHALL enter UNSEEDED with need_seed=1 and fault=0; no further grants until a seed load.
REQ-030 seed_load in the same edge as a pending req in SERVE SHALL take priority: no grant; request stays pending.
REQ-031 Requests arriving in UNSEEDED, WARMUP or FAULT SHALL wait without grant and without loss.

Reset
REQ-032 On rst=1, outputs SHALL immediately become: gnt=0, rnd_valid=0, rnd_out=0, fault=0, need_seed=1.
REQ-033 On rst=1: lfsr=0, counters=0, previous-word register=0, round-robin pointer such that index 0 is highest, state=UNSEEDED.
REQ-034 rst asserted mid-grant SHALL clear gnt and rnd_valid within the same cycle, with no partial delivery.

Verification
REQ-035 Reset, then req=4'b1111 for 50 cycles with no seed -> gnt=0 throughout, need_seed=1.
REQ-036 seed=0x00000001 load, WARMUP_CYCLES=4 -> SERVE entered with LFSR=0x00000010; req[2] at that edge -> next cycle gnt=4'b0100, rnd_out=0x00000010.
REQ-037 req=4'b1111 held in SERVE -> grants rotate 0,1,2,3,0; each rnd_out matches the reference LFSR model; rnd_out=0 between grants.
REQ-038 seed=0x00000000 load -> next cycle fault=1, need_seed=1; then seed=0xACE1ACE1 load -> fault=0, WARMUP resumes.
REQ-039 RESEED_LIMIT=8 with continuous req -> exactly 8 grants, then need_seed=1 and no grant until the next seed_load.
REQ-040 seed_load and req[1] at the same edge in SERVE -> no gnt that cycle; gnt[1] after warmup completes.
